// File: rtl/pbka_player_pkg.sv
// Shared types for the channel-A playback buffer: FSM states and stereo word packing.
package pbka_pkg;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 2 * SAMPLE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } pbka_state_t;

    // Left channel occupies the upper half of the word.
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] l;
        logic signed [SAMPLE_W-1:0] r;
    } stereo_t;

    function automatic stereo_t unpack_stereo(input logic [WORD_W-1:0] w);
        return stereo_t'(w);
    endfunction

    function automatic logic [WORD_W-1:0] pack_stereo(input stereo_t s);
        return {s.l, s.r};
    endfunction

endpackage

// File: rtl/pbka_player_if.sv
// Register-block write path into the playback buffer.
interface pbka_player_if;
    logic [31:0] pbka_wr_data;
    logic        pbka_wr_en;
    logic        pbka_full;

    modport master (output pbka_wr_data, output pbka_wr_en, input pbka_full);
    modport slave  (input pbka_wr_data, input pbka_wr_en, output pbka_full);
endinterface

// File: rtl/pbka_player_sync_fifo.sv
// Single-clock FIFO on an inferred block RAM with registered read data and
// a separately tracked occupancy counter.
module sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_MAX = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE = (DEPTH_LOG2+1)'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level_d;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full && !reset && !flush;
    assign do_pop  = pop && !empty && !reset;

    always_comb begin
        level_d = level;
        case ({do_push, do_pop})
            2'b10:   level_d = level + LVL_ONE;
            2'b01:   level_d = level - LVL_ONE;
            default: level_d = level;
        endcase
    end

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else if (do_pop)
            rd_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_d;
            full  <= (level_d == LVL_MAX);
            empty <= (level_d == '0);
        end
    end

endmodule

// File: rtl/pbka_player.sv
// Channel-A playback buffer: FIFO of stereo words released one per sample strobe,
// gated by an IDLE/PRIME/PLAY state machine, with underrun/overflow counters.
module pbka_player
    import pbka_pkg::*;
#(
    parameter int DEPTH_LOG2  = 9,
    parameter int START_LEVEL = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    pbka_player_if.slave          wr_bus,
    input  logic                  sample_stb,
    output logic [SAMPLE_W-1:0]   out_l,
    output logic [SAMPLE_W-1:0]   out_r,
    output logic                  out_valid,
    output logic                  playing,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           underrun_count,
    output logic [15:0]           overflow_count
);
    localparam logic [DEPTH_LOG2:0] START_LVL = (DEPTH_LOG2+1)'(START_LEVEL);

    pbka_state_t       state_q, state_d;
    logic [WORD_W-1:0] rd_data;
    stereo_t           rd_s;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push, pop, underrun, overflow;
    logic              zero_q;

    assign push     = wr_bus.pbka_wr_en && !fifo_full && !flush;
    assign overflow = wr_bus.pbka_wr_en && fifo_full && !flush;
    assign pop      = sample_stb && (state_q == PLAY) && !fifo_empty && !flush;
    assign underrun = sample_stb && (state_q == PLAY) && fifo_empty;

    sync_fifo #(
        .WIDTH      (WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (wr_bus.pbka_wr_data),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign wr_bus.pbka_full = fifo_full;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (enable) state_d = PRIME;
                PRIME:   if (!enable) state_d = IDLE;
                         else if (level >= START_LVL) state_d = PLAY;
                PLAY:    if (!enable) state_d = IDLE;
                         else if (underrun) state_d = PRIME;
                default: state_d = IDLE;
            endcase
        end
    end

    // The FIFO read register holds the popped word; zero_q masks it for strobes that did not pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            out_valid <= sample_stb;
            if (sample_stb) zero_q <= !pop;
        end
    end

    assign rd_s    = unpack_stereo(rd_data);
    assign out_l   = zero_q ? '0 : rd_s.l;
    assign out_r   = zero_q ? '0 : rd_s.r;
    assign playing = (state_q == PLAY);

    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_count <= '0;
            overflow_count <= '0;
        end else begin
            if (underrun && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
            if (overflow && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
        end
    end

endmodule
